// File: rtl/stack_controller.sv
// Stack pointer / stack memory sequencer for PUSH, POP and LOAD commands.
// Full-descending stack driven over a single-outstanding req/ack memory port.
module stack_controller #(
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DW       = 16,
    parameter logic [AW-1:0]  SP_BASE  = 16'h0400,
    parameter logic [AW-1:0]  SP_LIMIT = 16'h0300
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] sp,
    output logic          empty,
    output logic          full
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    localparam logic [AW-1:0] SP_ONE = AW'(1);

    state_t state;
    state_t state_nx;
    logic   accept;

    assign empty  = (sp == SP_BASE);
    assign full   = (sp == SP_LIMIT);
    assign accept = cmd_valid && (state == IDLE);

    // Handshake outputs decode straight from the state, so a reset drops mem_req at once.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_req   = (state == WRITE) || (state == READ);
    assign mem_we    = (state == WRITE);

    // NOTE: state register uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: default assigned first so no path through the case leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: state_nx = full  ? RESP : WRITE;
                        OP_POP:  state_nx = empty ? RESP : READ;
                        OP_LOAD: state_nx = RESP;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            WRITE, READ: begin
                if (mem_ack) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= SP_BASE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                case (cmd_op)
                    OP_PUSH: begin
                        if (full) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else begin
                            mem_addr  <= sp - SP_ONE;
                            mem_wdata <= cmd_data;
                        end
                    end
                    OP_POP: begin
                        if (empty) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else begin
                            mem_addr <= sp;
                        end
                    end
                    OP_LOAD: begin
                        sp       <= cmd_data[AW-1:0];
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // SP only moves once memory confirms, so an aborted transfer leaves it untouched.
            if (mem_ack && (state == WRITE)) begin
                sp       <= sp - SP_ONE;
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end

            if (mem_ack && (state == READ)) begin
                sp       <= sp + SP_ONE;
                rsp_data <= mem_rdata;
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller: directed commands, a latency-programmable
// memory responder, and a monitor that checks every response against a reference model.
module tb_stack_controller;

    localparam logic [15:0] SP_BASE  = 16'h0400;
    localparam logic [15:0] SP_LIMIT = 16'h0300;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [15:0] sp;
    } rsp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] sp;
    logic        empty;
    logic        full;

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;

    rsp_t        exp_rsp[$];
    mreq_t       exp_mem[$];
    logic [15:0] model_mem[logic [15:0]];
    logic [15:0] ram[logic [15:0]];
    logic [15:0] model_sp = SP_BASE;

    stack_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .sp        (sp),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err",  32'(rsp_err),  32'(e.err));
                check("rsp_sp",   32'(sp),       32'(e.sp));
            end
        end
    end

    // Memory responder: checks each new request, watches it stay stable, acks after ack_delay cycles.
    initial begin
        bit          in_req = 1'b0;
        int          cnt = 0;
        logic [15:0] req_addr = '0;
        logic        req_we = 1'b0;
        logic [15:0] req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    cnt       = 0;
                    req_addr  = mem_addr;
                    req_we    = mem_we;
                    req_wdata = mem_wdata;
                    if (exp_mem.size() == 0) begin
                        check("unexpected_mem_req", 32'(mem_req), 32'd0);
                    end else begin
                        mreq_t m;
                        m = exp_mem.pop_front();
                        check("mem_addr", 32'(mem_addr), 32'(m.addr));
                        check("mem_we",   32'(mem_we),   32'(m.we));
                        if (m.we) check("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                    end
                end else begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(req_addr));
                    check("mem_we_stable",   32'(mem_we),   32'(req_we));
                    if (req_we) check("mem_wdata_stable", 32'(mem_wdata), 32'(req_wdata));
                end
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (req_we) ram[req_addr] = req_wdata;
                    mem_rdata = ram.exists(req_addr) ? ram[req_addr] : 16'h0000;
                    in_req = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Issue one command: wait (bounded) for cmd_ready, record expectations, hold cmd_valid one edge.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input int delay);
        int   n = 0;
        rsp_t r;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        ack_delay = delay;
        case (op)
            OP_PUSH: begin
                if (model_sp == SP_LIMIT) begin
                    r = '{16'h0000, 1'b1, model_sp};
                end else begin
                    model_sp = model_sp - 16'd1;
                    model_mem[model_sp] = data;
                    exp_mem.push_back('{model_sp, 1'b1, data});
                    r = '{16'h0000, 1'b0, model_sp};
                end
                exp_rsp.push_back(r);
            end
            OP_POP: begin
                if (model_sp == SP_BASE) begin
                    r = '{16'h0000, 1'b1, model_sp};
                end else begin
                    exp_mem.push_back('{model_sp, 1'b0, 16'h0000});
                    r.data = model_mem.exists(model_sp) ? model_mem[model_sp] : 16'h0000;
                    r.err  = 1'b0;
                    model_sp = model_sp + 16'd1;
                    r.sp   = model_sp;
                end
                exp_rsp.push_back(r);
            end
            OP_LOAD: begin
                model_sp = data;
                exp_rsp.push_back('{16'h0000, 1'b0, model_sp});
            end
            default: ;
        endcase
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && !rsp_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sp",        32'(sp),        32'(SP_BASE));
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait PUSH: req in N+1, rsp in N+2, ready again in N+3.
        do_cmd(OP_PUSH, 16'hA42F, 0);
        @(negedge clk);
        check("push0_req_n1",   32'(mem_req),   32'd1);
        check("push0_rsp_n1",   32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("push0_rsp_n2",   32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("push0_rsp_n3",   32'(rsp_valid), 32'd0);
        check("push0_ready_n3", 32'(cmd_ready), 32'd1);
        check("push0_sp",       32'(sp),        32'h03FF);

        // Delayed acks: request held stable, POP returns the pushed word.
        do_cmd(OP_PUSH, 16'h9BC2, 3);
        do_cmd(OP_POP,  16'h0000, 3);
        wait_idle();
        check("pushpop_sp", 32'(sp), 32'h03FF);

        // NOP is accepted with no response; a command while busy is ignored.
        do_cmd(OP_NOP, 16'h1234, 0);
        do_cmd(OP_PUSH, 16'h5555, 4);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 16'h0123;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        wait_idle();
        check("busy_ignored_sp", 32'(sp), 32'h03FE);

        // Underflow: POP on an empty stack.
        do_cmd(OP_LOAD, SP_BASE, 0);
        wait_idle();
        check("load_base_empty", 32'(empty), 32'd1);
        do_cmd(OP_POP, 16'h0000, 0);
        wait_idle();
        check("underflow_sp", 32'(sp), 32'(SP_BASE));

        // Overflow: LOAD to the limit, then PUSH.
        do_cmd(OP_LOAD, SP_LIMIT, 0);
        wait_idle();
        check("load_limit_full",  32'(full),  32'd1);
        check("load_limit_empty", 32'(empty), 32'd0);
        do_cmd(OP_PUSH, 16'h7D10, 0);
        wait_idle();
        check("overflow_sp", 32'(sp), 32'(SP_LIMIT));

        // Reset while a READ is outstanding.
        do_cmd(OP_LOAD, 16'h03FE, 0);
        wait_idle();
        do_cmd(OP_POP, 16'h0000, 50);
        repeat (2) @(posedge clk);
        #1;
        check("midread_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midread_req_dropped", 32'(mem_req), 32'd0);
        check("midread_sp",          32'(sp),      32'(SP_BASE));
        void'(exp_rsp.pop_back());
        model_sp = SP_BASE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midread_ready", 32'(cmd_ready), 32'd1);

        // Normal operation resumes after the aborted transfer.
        do_cmd(OP_PUSH, 16'h1357, 1);
        do_cmd(OP_POP,  16'h0000, 2);
        wait_idle();
        check("resume_sp",    32'(sp),    32'(SP_BASE));
        check("resume_empty", 32'(empty), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
